matrix_alu: RTL and testbench

- Execute stage directly upstream of the matrix data memory.
- Consumes two WIDTH x WIDTH matrices of 32-bit elements, taken from the memory read ports (data1 feeds a, data2 feeds b, including the generated constant matrix).
- Computes add, sub, element-wise product or matrix product.
- Drives the memory write port (write_enable, write, write_data) with a registered result and a one-cycle write strobe.

---
 rtl/matrix_alu_pkg.sv | 27 ++
 rtl/matrix_alu_pe.sv | 24 ++
 rtl/matrix_alu.sv | 168 ++++++++++++++++
 tb/tb_matrix_alu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_alu_pkg.sv
// ============================================================================
// Module   : matrix_alu_pkg
// Brief    : Shared constants, opcodes and FSM encoding for the matrix ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_alu_pkg;

    localparam int c_WIDTH_BIT = 1;
    localparam int c_INDEX_BIT = 4;
    localparam int c_OP_BIT    = 2;

    localparam logic [c_OP_BIT-1:0] c_OP_ADD      = 2'b00;
    localparam logic [c_OP_BIT-1:0] c_OP_SUB      = 2'b01;
    localparam logic [c_OP_BIT-1:0] c_OP_MATMUL   = 2'b10;
    localparam logic [c_OP_BIT-1:0] c_OP_HADAMARD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/matrix_alu_pe.sv
// ============================================================================
// Module   : matrix_pe
// Brief    : One 32-bit multiply-accumulate lane (modular arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_pe (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] acc_in,
    input  logic        first,
    output logic [31:0] acc_in_next
);

    logic [31:0] w_prod;

    // 32-bit context keeps only the low half of the product
    assign w_prod      = x * y;
    assign acc_in_next = first ? w_prod : (acc_in + w_prod);

endmodule

`default_nettype wire

// File: rtl/matrix_alu.sv
// ============================================================================
// Module   : matrix_alu
// Brief    : Matrix execute stage (ADD/SUB/MATMUL/HADAMARD) driving the
//            matrix data memory write port with a registered result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_alu
    import matrix_alu_pkg::*;
#(
    parameter int WIDTH_BIT = c_WIDTH_BIT,
    parameter int WIDTH     = 2 ** WIDTH_BIT,
    parameter int IDX       = c_INDEX_BIT
) (
    input  logic                                    CLK,
    input  logic                                    RST_N,
    input  logic                                    start,
    input  logic [c_OP_BIT-1:0]                     op,
    input  logic [IDX-1:0]                          dest,
    input  logic [0:WIDTH-1][0:WIDTH-1][31:0]       a,
    input  logic [0:WIDTH-1][0:WIDTH-1][31:0]       b,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    write_enable,
    output logic [IDX-1:0]                          write,
    output logic [0:WIDTH-1][0:WIDTH-1][31:0]       result
);

    localparam int KW = (WIDTH_BIT < 1) ? 1 : WIDTH_BIT;

    state_e                              r_state;
    state_e                              w_next;
    logic [0:WIDTH-1][0:WIDTH-1][31:0]   r_a;
    logic [0:WIDTH-1][0:WIDTH-1][31:0]   r_b;
    logic [0:WIDTH-1][0:WIDTH-1][31:0]   r_acc;
    logic [0:WIDTH-1][0:WIDTH-1][31:0]   r_result;
    logic [0:WIDTH-1][0:WIDTH-1][31:0]   w_mac;
    logic [0:WIDTH-1][0:WIDTH-1][31:0]   w_res;
    logic [c_OP_BIT-1:0]                 r_op;
    logic [IDX-1:0]                      r_dest;
    logic [IDX-1:0]                      r_write;
    logic [KW-1:0]                       r_k;
    logic                                r_busy;
    logic                                r_done;
    logic                                r_we;
    logic                                w_last_k;
    logic                                w_is_mm;

    assign w_is_mm  = (r_op == c_OP_MATMUL);
    assign w_last_k = (r_k == KW'(WIDTH - 1));

    // Per-lane operand select: MATMUL walks k, element-wise ops use lane (i,j)
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
        for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
            logic [31:0] w_x;
            logic [31:0] w_y;
            logic        w_first;
            logic [31:0] w_pe_out;
            logic [31:0] w_lane_res;

            always_comb begin
                w_x     = r_a[gi][gj];
                w_y     = r_b[gi][gj];
                w_first = 1'b1;
                if (w_is_mm) begin
                    w_x     = r_a[gi][r_k];
                    w_y     = r_b[r_k][gj];
                    w_first = (r_k == '0);
                end
            end

            matrix_pe u_pe (
                .x           (w_x),
                .y           (w_y),
                .acc_in      (r_acc[gi][gj]),
                .first       (w_first),
                .acc_in_next (w_pe_out)
            );

            always_comb begin
                case (r_op)
                    c_OP_ADD: w_lane_res = r_a[gi][gj] + r_b[gi][gj];
                    c_OP_SUB: w_lane_res = r_a[gi][gj] - r_b[gi][gj];
                    default:  w_lane_res = w_pe_out;
                endcase
            end

            assign w_mac[gi][gj] = w_pe_out;
            assign w_res[gi][gj] = w_lane_res;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_EXEC;
            ST_EXEC:  if (!w_is_mm || w_last_k) w_next = ST_WRITE;
            ST_WRITE: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_op     <= '0;
            r_dest   <= '0;
            r_write  <= '0;
            r_k      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_op   <= op;
                        r_dest <= dest;
                        r_k    <= '0;
                        r_busy <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (w_is_mm) begin
                        r_acc <= w_mac;
                        r_k   <= r_k + 1'b1;
                    end
                    if (w_next == ST_WRITE) begin
                        r_result <= w_res;
                        r_write  <= r_dest;
                        r_we     <= 1'b1;
                        r_done   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_we   <= 1'b0;
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_we   <= 1'b0;
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign write_enable = r_we;
    assign write        = r_write;
    assign result       = r_result;

endmodule

`default_nettype wire

// File: tb/tb_matrix_alu.sv
// ============================================================================
// Module   : tb_matrix_alu
// Brief    : Self-checking bench for matrix_alu (WIDTH=2) against a
//            plain-arithmetic matrix reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_alu;
    import matrix_alu_pkg::*;

    localparam int W   = 2;
    localparam int IDX = 4;

    typedef logic [0:W-1][0:W-1][31:0] mat_t;

    logic             CLK;
    logic             RST_N;
    logic             start;
    logic [1:0]       op;
    logic [IDX-1:0]   dest;
    mat_t             a;
    mat_t             b;
    logic             busy;
    logic             done;
    logic             write_enable;
    logic [IDX-1:0]   write;
    mat_t             result;

    int n_vec  = 0;
    int n_miss = 0;

    matrix_alu #(.WIDTH_BIT(1), .WIDTH(W), .IDX(IDX)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .start        (start),
        .op           (op),
        .dest         (dest),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .write_enable (write_enable),
        .write        (write),
        .result       (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: textbook matrix arithmetic, all mod 2^32
    function automatic mat_t model(input logic [1:0] o, input mat_t x, input mat_t y);
        mat_t        r;
        logic [31:0] s;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                case (o)
                    2'b00: r[i][j] = x[i][j] + y[i][j];
                    2'b01: r[i][j] = x[i][j] - y[i][j];
                    2'b11: r[i][j] = x[i][j] * y[i][j];
                    default: begin
                        s = 32'd0;
                        for (int k = 0; k < W; k++) s = s + x[i][k] * y[k][j];
                        r[i][j] = s;
                    end
                endcase
            end
        end
        return r;
    endfunction

    function automatic mat_t mk(input logic [31:0] e00, input logic [31:0] e01,
                                input logic [31:0] e10, input logic [31:0] e11);
        mat_t m;
        m[0][0] = e00; m[0][1] = e01; m[1][0] = e10; m[1][1] = e11;
        return m;
    endfunction

    function automatic mat_t rnd_mat();
        mat_t m;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++) m[i][j] = $urandom;
        return m;
    endfunction

    task automatic do_op(input string tag, input logic [1:0] o, input logic [IDX-1:0] d,
                         input mat_t x, input mat_t y);
        mat_t exp;
        int   cnt;
        exp = model(o, x, y);
        @(negedge CLK);
        op = o; dest = d; a = x; b = y; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        // scramble inputs to prove operands were latched
        op = ~o; dest = ~d; a = ~x; b = ~y;
        chk({tag, ":busy_exec"}, 128'(busy), 128'(1));
        cnt = 0;
        while (!write_enable && cnt < 20) begin
            @(posedge CLK);
            @(negedge CLK);
            cnt++;
        end
        chk({tag, ":latency"}, 128'(cnt), 128'((o == c_OP_MATMUL) ? W : 1));
        chk({tag, ":write"}, 128'(write), 128'(d));
        chk({tag, ":result"}, 128'(result), 128'(exp));
        chk({tag, ":done"}, 128'(done), 128'(1));
        chk({tag, ":busy_wr"}, 128'(busy), 128'(1));
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, ":we_off"}, 128'(write_enable), 128'(0));
        chk({tag, ":busy_off"}, 128'(busy), 128'(0));
        chk({tag, ":hold"}, 128'(result), 128'(exp));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        mat_t m1, m2, ident, exp_first;
        int   strobes;
        logic [IDX-1:0] seen_wr;
        mat_t seen_res;

        RST_N = 1'b0; start = 1'b0; op = 2'b00; dest = '0; a = '0; b = '0;
        #12;
        chk("reset:busy", 128'(busy), 128'(0));
        chk("reset:done", 128'(done), 128'(0));
        chk("reset:we", 128'(write_enable), 128'(0));
        chk("reset:write", 128'(write), 128'(0));
        chk("reset:result", 128'(result), 128'(0));
        @(negedge CLK);
        RST_N = 1'b1;

        do_op("add", c_OP_ADD, 4'd3, mk(1, 2, 3, 4), mk(10, 20, 30, 40));
        chk("add:golden", 128'(result), 128'(mk(11, 22, 33, 44)));
        do_op("sub_wrap", c_OP_SUB, 4'd1, mk(0, 0, 0, 0), mk(1, 1, 1, 1));
        chk("sub:golden", 128'(result), 128'({4{32'hFFFF_FFFF}}));
        do_op("matmul", c_OP_MATMUL, 4'd7, mk(1, 2, 3, 4), mk(5, 6, 7, 8));
        chk("matmul:golden", 128'(result), 128'(mk(19, 22, 43, 50)));
        ident = mk(1, 0, 0, 1);
        m1 = rnd_mat();
        do_op("matmul_ident", c_OP_MATMUL, 4'd2, m1, ident);
        chk("matmul_ident:golden", 128'(result), 128'(m1));
        do_op("hadamard_ovf", c_OP_HADAMARD, 4'd9, {4{32'h0001_0000}}, {4{32'h0001_0003}});
        chk("hadamard:golden", 128'(result), 128'({4{32'h0003_0000}}));

        // second start during EXEC must be ignored
        m1 = mk(5, 6, 7, 8);
        m2 = mk(100, 200, 300, 400);
        exp_first = model(c_OP_ADD, m1, m2);
        @(negedge CLK);
        op = c_OP_ADD; dest = 4'd5; a = m1; b = m2; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        op = c_OP_SUB; dest = 4'd12; a = rnd_mat(); b = rnd_mat(); start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        strobes = 0; seen_wr = '0; seen_res = '0;
        for (int c = 0; c < 8; c++) begin
            if (write_enable) begin
                if (strobes == 0) begin
                    seen_wr  = write;
                    seen_res = result;
                end
                strobes++;
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("ignore:strobes", 128'(strobes), 128'(1));
        chk("ignore:write", 128'(seen_wr), 128'(4'd5));
        chk("ignore:result", 128'(seen_res), 128'(exp_first));

        // asynchronous reset in the k=1 cycle of a MATMUL
        @(negedge CLK);
        op = c_OP_MATMUL; dest = 4'd6; a = mk(1, 2, 3, 4); b = mk(5, 6, 7, 8); start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_mid:busy_before", 128'(busy), 128'(1));
        #1;
        RST_N = 1'b0;
        #1;
        chk("rst_mid:busy", 128'(busy), 128'(0));
        chk("rst_mid:done", 128'(done), 128'(0));
        chk("rst_mid:we", 128'(write_enable), 128'(0));
        chk("rst_mid:result", 128'(result), 128'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        strobes = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (write_enable) strobes++;
        end
        chk("rst_mid:no_strobe", 128'(strobes), 128'(0));
        do_op("post_rst_add", c_OP_ADD, 4'd4, mk(1, 1, 1, 1), mk(1, 1, 1, 1));
        chk("post_rst:golden", 128'(result), 128'(mk(2, 2, 2, 2)));

        for (int n = 0; n < 16; n++) begin
            logic [1:0]     ro;
            logic [IDX-1:0] rd;
            ro = 2'($urandom_range(0, 3));
            rd = IDX'($urandom);
            do_op("random", ro, rd, rnd_mat(), rnd_mat());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
